// File: rtl/inst_fetch_pkg.sv
// Shared widths, state encodings and helpers for the instruction-fetch bridge.
package inst_fetch_pkg;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  // state | meaning
  // IDLE  | waiting for a valid PC to sample
  // ADDR  | read request on the bus, waiting for addr_ok
  // DATA  | request accepted, waiting for data_ok
  // HOLD  | instruction presented to ID, waiting for it to be taken
  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_ADDR = 2'd1;
  localparam logic [1:0] IF_DATA = 2'd2;
  localparam logic [1:0] IF_HOLD = 2'd3;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Word fetches need the two low address bits clear.
  function automatic logic is_aligned(input logic [W_ADDR-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch bridge: turns the PC into one SRAM-like word read,
// holds the returned word for ID and stalls the PC until it is taken.
// A flush while a read is in flight lets the bus transaction finish but
// throws its data away.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [W_ADDR-1:0] pc_addr,
  input  logic              flush,
  input  logic              id_stall,
  output logic              if_stall,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [W_ADDR-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [W_DATA-1:0] inst_rdata,
  output logic              inst_valid,
  output logic [W_DATA-1:0] inst,
  output logic [W_ADDR-1:0] inst_pc,
  output logic              inst_adel
);

  logic [1:0]        state_q,  state_d;
  logic              cancel_q, cancel_d;
  logic [W_ADDR-1:0] addr_q,   addr_d;
  logic [W_DATA-1:0] inst_q,   inst_d;
  logic [W_ADDR-1:0] pc_q,     pc_d;
  logic              adel_q,   adel_d;

  // Next-state and datapath capture for the fetch sequence.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    adel_d   = adel_q;
    case (state_q)
      IF_IDLE: begin
        if (pc_valid && !flush) begin
          if (is_aligned(pc_addr)) begin
            addr_d  = pc_addr;
            state_d = IF_ADDR;
          end else begin
            // Misaligned PC never reaches the bus; deliver a nop with the fault flag.
            inst_d  = '0;
            pc_d    = pc_addr;
            adel_d  = 1'b1;
            state_d = IF_HOLD;
          end
        end
      end
      IF_ADDR: begin
        // The request must stay up until accepted, so a flush only marks it.
        if (flush) begin
          cancel_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = IF_DATA;
        end
      end
      IF_DATA: begin
        if (inst_data_ok) begin
          // A flush landing on the data_ok cycle also makes the word stale.
          if (cancel_q || flush) begin
            cancel_d = 1'b0;
            state_d  = IF_IDLE;
          end else begin
            inst_d  = inst_rdata;
            pc_d    = addr_q;
            adel_d  = 1'b0;
            state_d = IF_HOLD;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (flush || !id_stall) begin
          state_d = IF_IDLE;
        end
      end
      default: begin
        state_d = IF_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IF_IDLE;
      cancel_q <= 1'b0;
      addr_q   <= '0;
      inst_q   <= '0;
      pc_q     <= '0;
      adel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      adel_q   <= adel_d;
    end
  end

  // Bus and ID-side outputs decoded from the registered state.
  always_comb begin
    inst_req   = (state_q == IF_ADDR);
    inst_wr    = 1'b0;
    inst_size  = SIZE_WORD;
    inst_addr  = addr_q;
    inst_valid = (state_q == IF_HOLD) && !cancel_q && !flush;
    inst       = inst_q;
    inst_pc    = pc_q;
    inst_adel  = adel_q;
    // The PC moves only when HOLD hands off or when a flush redirects it.
    if_stall   = !flush && !((state_q == IF_HOLD) && !id_stall);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a PC model, a latency-programmable memory slave and a
// scoreboard monitor that checks every instruction ID accepts.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        flush;
  logic        id_stall;
  logic        if_stall;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_adel;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_valid     (pc_valid),
    .pc_addr      (pc_addr),
    .flush        (flush),
    .id_stall     (id_stall),
    .if_stall     (if_stall),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_adel    (inst_adel)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          valid_cnt = 0;
  logic [31:0] pc;
  logic [31:0] flush_target;

  int          addr_lat;
  int          data_lat;
  bit          force_bad;
  int          ack_cnt = 0;
  logic [31:0] last_ack_addr;

  assign pc_addr = pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h24020001 + (a << 4);
  endfunction

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.adel = (a[1:0] != 2'b00);
    e.inst = e.adel ? 32'h0 : mem_word(a);
    return e;
  endfunction

  // PC register model; each new address it presents is a fetch expected at ID.
  always @(posedge clk) begin
    if (rst) begin
      pc <= 32'h0;
      sb.delete();
      sb.push_back(mk(32'h0));
    end else if (flush) begin
      pc <= flush_target;
      sb.delete();
      sb.push_back(mk(flush_target));
    end else if (pc_valid && !if_stall) begin
      pc <= pc + 32'd4;
      sb.push_back(mk(pc + 32'd4));
    end
  end

  // Memory slave: addr_ok after addr_lat waiting cycles, data_ok data_lat cycles later.
  initial begin : mem_slave
    bit          m_busy;
    int          m_wait;
    int          m_cnt;
    logic [31:0] m_addr;
    m_busy = 0; m_wait = 0; m_cnt = 0; m_addr = 0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (rst) begin
        m_busy = 0;
        m_wait = 0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = force_bad ? 32'hDEADBEEF : mem_word(m_addr);
          force_bad    = 0;
          m_busy       = 0;
        end else begin
          m_cnt--;
        end
      end else if (inst_req) begin
        if (m_wait >= addr_lat) begin
          inst_addr_ok  = 1'b1;
          m_busy        = 1;
          m_cnt         = data_lat - 1;
          m_addr        = inst_addr;
          last_ack_addr = inst_addr;
          ack_cnt++;
          m_wait        = 0;
        end else begin
          m_wait++;
        end
      end
    end
  end

  // Scoreboard monitor: every instruction ID takes must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (inst_valid) valid_cnt++;
      if (!rst && inst_valid && !id_stall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_deliver: got inst %h pc %h with nothing expected", inst, inst_pc);
        end else begin
          e = sb.pop_front();
          if (inst !== e.inst || inst_pc !== e.pc || inst_adel !== e.adel) begin
            n_bad++;
            $display("FAIL sb_deliver: got inst %h pc %h adel %b want inst %h pc %h adel %b",
                     inst, inst_pc, inst_adel, e.inst, e.pc, e.adel);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic sig(input int w);
    return (w == 0) ? inst_valid : inst_req;
  endfunction

  task automatic wait_sig(input int w, input string nm);
    int n = 0;
    while (!sig(w) && n < 60) begin
      tick();
      n++;
    end
    if (!sig(w)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout want signal high", nm);
    end
  endtask

  task automatic wait_ack(input logic [31:0] exp_addr, input bit do_chk, input string nm);
    int s = ack_cnt;
    int n = 0;
    while (ack_cnt == s && n < 60) begin
      tick();
      n++;
    end
    if (ack_cnt == s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout want addr_ok", nm);
    end else if (do_chk) begin
      chk(nm, last_ack_addr, exp_addr);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  logic exp_valid [1:5];
  logic exp_stall [1:5];
  logic exp_req   [1:5];
  int   v0;
  logic req_seen;

  initial begin : stim
    exp_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_req   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; pc_valid = 1'b0; flush = 1'b0; id_stall = 1'b0;
    flush_target = 32'h0; addr_lat = 0; data_lat = 1; force_bad = 0;
    repeat (3) @(negedge clk);

    // Reset state, then straight-line fetch from 0x0.
    rst = 1'b0; pc_valid = 1'b1;
    #2;
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_req",   {31'b0, inst_req},   32'h0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc",    inst_pc,             32'h0);
    chk("rst_addr",  inst_addr,           32'h0);
    chk("rst_adel",  {31'b0, inst_adel},  32'h0);
    chk("inst_wr",   {31'b0, inst_wr},    32'h0);
    chk("inst_size", {30'b0, inst_size},  32'h2);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("line_valid_c%0d", k), {31'b0, inst_valid}, {31'b0, exp_valid[k]});
      chk($sformatf("line_stall_c%0d", k), {31'b0, if_stall},   {31'b0, exp_stall[k]});
      chk($sformatf("line_req_c%0d", k),   {31'b0, inst_req},   {31'b0, exp_req[k]});
      if (k == 3) begin
        chk("line_inst", inst,    32'h24020001);
        chk("line_pc",   inst_pc, 32'h0);
      end
    end
    chk("line_next_addr", inst_addr, 32'h4);

    // ID back-pressure for three HOLD cycles.
    @(negedge clk); id_stall = 1'b1; #2;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk("bp_valid", {31'b0, inst_valid}, 32'h1);
      chk("bp_inst",  inst,                mem_word(32'h4));
      chk("bp_pc",    inst_pc,             32'h4);
      chk("bp_stall", {31'b0, if_stall},   32'h1);
      chk("bp_pcreg", pc,                  32'h4);
    end
    @(negedge clk); id_stall = 1'b0; #2;
    chk("bp_release_stall", {31'b0, if_stall}, 32'h0);
    tick();
    chk("bp_pc_adv", pc, 32'h8);

    // Flush while waiting for data; the late 0xDEADBEEF must be dropped.
    data_lat = 3; force_bad = 1;
    wait_ack(32'h8, 1, "ack_8");
    @(negedge clk); flush = 1'b1; flush_target = 32'hBFC00380; #2;
    v0 = valid_cnt;
    @(negedge clk); flush = 1'b0; #2;
    wait_ack(32'hBFC00380, 1, "redirect_data_addr");
    chk("data_flush_no_valid", valid_cnt, v0);
    data_lat = 1;

    // Flush in ADDR while addr_ok is withheld for two cycles.
    wait_sig(0, "valid_bfc");
    addr_lat = 2;
    wait_sig(1, "req_after_bfc");
    @(negedge clk); flush = 1'b1; flush_target = 32'h80000000; #2;
    chk("addr_flush_req",   {31'b0, inst_req},     32'h1);
    chk("addr_flush_no_ok", {31'b0, inst_addr_ok}, 32'h0);
    v0 = valid_cnt;
    @(negedge clk); flush = 1'b0; #2;
    chk("addr_held_req", {31'b0, inst_req},     32'h1);
    chk("addr_held_ok",  {31'b0, inst_addr_ok}, 32'h1);
    wait_ack(32'h80000000, 1, "redirect_addr_addr");
    chk("addr_flush_no_valid", valid_cnt, v0);
    addr_lat = 0;

    // Flush out of HOLD onto a misaligned PC.
    @(negedge clk); id_stall = 1'b1; #2;
    wait_sig(0, "valid_8000");
    @(negedge clk); flush = 1'b1; flush_target = 32'h6; #2;
    chk("hold_flush_valid", {31'b0, inst_valid}, 32'h0);
    req_seen = inst_req;
    @(negedge clk); flush = 1'b0; #2;
    chk("adel_idle_valid", {31'b0, inst_valid}, 32'h0);
    req_seen |= inst_req;
    tick();
    req_seen |= inst_req;
    chk("adel_valid", {31'b0, inst_valid}, 32'h1);
    chk("adel_flag",  {31'b0, inst_adel},  32'h1);
    chk("adel_inst",  inst,                32'h0);
    chk("adel_pc",    inst_pc,             32'h6);
    @(negedge clk); id_stall = 1'b0; #2;
    for (int i = 0; i < 6; i++) begin
      tick();
      req_seen |= inst_req;
    end
    chk("adel_no_req", {31'b0, req_seen}, 32'h0);

    // Reset in the middle of a DATA wait.
    @(negedge clk); rst = 1'b1; pc_valid = 1'b0; #2;
    tick(); tick();
    @(negedge clk); rst = 1'b0; pc_valid = 1'b1; #2;
    wait_ack(32'h0, 1, "rst_fetch0");
    wait_ack(32'h4, 0, "rst_fetch4");
    data_lat = 3;
    wait_ack(32'h8, 1, "rst_fetch8");
    @(negedge clk); rst = 1'b1; #2;
    tick();
    chk("mid_rst_req",   {31'b0, inst_req},   32'h0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("mid_rst_inst",  inst,                32'h0);
    chk("mid_rst_pc",    inst_pc,             32'h0);
    chk("mid_rst_addr",  inst_addr,           32'h0);
    chk("mid_rst_adel",  {31'b0, inst_adel},  32'h0);
    chk("mid_rst_stall", {31'b0, if_stall},   32'h1);
    @(negedge clk); rst = 1'b0; data_lat = 1; #2;
    wait_ack(32'h0, 1, "restart_addr");
    wait_sig(0, "restart_valid");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
